// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings and types for the MEM-stage data access unit.
// Imported by the lane aligner and the handshake top.
package dmem_access_unit_pkg;

    localparam logic [1:0] MEM_NOOP = 2'b00;
    localparam logic [1:0] MEM_LOAD = 2'b01;
    localparam logic [1:0] MEM_STOR = 2'b10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } dmem_state_t;

    // Size 2'b11 is illegal and behaves as a word access.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
        logic is_half;
        logic is_word;
        is_half = (size == SZ_HALF);
        is_word = (size == SZ_WORD) || (size == 2'b11);
        return (is_half && off[0]) || (is_word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store strobe/data replication and
// load lane extraction with sign or zero extension. Purely combinational.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]  mem_size_i,
    input  logic        mem_signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = store_data_i;
        case (mem_size_i)
            SZ_BYTE: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
    end

    always_comb begin
        load_byte = load_word_i[7:0];
        case (addr_lo_i)
            2'd0: load_byte = load_word_i[7:0];
            2'd1: load_byte = load_word_i[15:8];
            2'd2: load_byte = load_word_i[23:16];
            default: load_byte = load_word_i[31:24];
        endcase
        load_half = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    end

    always_comb begin
        rdata_o = load_word_i;
        case (mem_size_i)
            SZ_BYTE: rdata_o = {{24{mem_signed_i & load_byte[7]}}, load_byte};
            SZ_HALF: rdata_o = {{16{mem_signed_i & load_half[15]}}, load_half};
            default: rdata_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data bus engine: issues one request per load/store, waits for the
// response, and holds the pipeline via mem_stall until the result is ready.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_type,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              dbus_req,
    input  logic              dbus_ready,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_wstrb,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              addr_error,
    output logic              mem_stall
);

    dmem_state_t       state_q, state_d;
    logic [DATA_W-1:0] raw_q, raw_d;

    logic        op_valid;
    logic        is_store;
    logic        misaligned;
    logic        legal_op;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;

    assign op_valid   = (mem_type != MEM_NOOP);
    assign is_store   = (mem_type == MEM_STOR);
    assign misaligned = is_misaligned(mem_size, mem_addr[1:0]);
    assign legal_op   = op_valid && !misaligned;

    dmem_lane_align u_lane_align (
        .mem_size_i   (mem_size),
        .mem_signed_i (mem_signed),
        .addr_lo_i    (mem_addr[1:0]),
        .store_data_i (mem_wdata),
        .load_word_i  (raw_q),
        .wstrb_o      (align_wstrb),
        .wdata_o      (align_wdata),
        .rdata_o      (align_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        raw_d   = raw_q;
        case (state_q)
            StIdle: begin
                if (legal_op && dbus_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dbus_rvalid) begin
                    raw_d   = dbus_rdata;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced quiet while reset is held, even with an op presented.
    always_comb begin
        dbus_req  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            StIdle: begin
                dbus_req  = legal_op;
                mem_stall = legal_op;
            end
            StWait: begin
                mem_stall = 1'b1;
            end
            default: begin
                dbus_req  = 1'b0;
                mem_stall = 1'b0;
            end
        endcase
        if (rst) begin
            dbus_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    assign addr_error = !rst && op_valid && misaligned;
    assign dbus_addr  = {mem_addr[ADDR_W-1:2], 2'b00};
    assign dbus_wstrb = is_store ? align_wstrb : 4'b0000;
    assign dbus_wdata = align_wdata;
    assign mem_rdata  = is_store ? '0 : align_rdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a transaction-level reference model
// checked every cycle plus literal expectations from hand-worked vectors.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_type;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        dbus_req;
    logic        dbus_ready;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic [31:0] mem_rdata;
    logic        addr_error;
    logic        mem_stall;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_type    (mem_type),
        .mem_size    (mem_size),
        .mem_signed  (mem_signed),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .dbus_req    (dbus_req),
        .dbus_ready  (dbus_ready),
        .dbus_addr   (dbus_addr),
        .dbus_wstrb  (dbus_wstrb),
        .dbus_wdata  (dbus_wdata),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata),
        .mem_rdata   (mem_rdata),
        .addr_error  (addr_error),
        .mem_stall   (mem_stall)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int nbytes(logic [1:0] size);
        if (size == SZ_BYTE) return 1;
        if (size == SZ_HALF) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(logic [1:0] size, logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(logic [1:0] size, logic [31:0] addr);
        int nb;
        int o;
        logic [3:0] s;
        nb = nbytes(size);
        o  = int'(addr[1:0]) - (int'(addr[1:0]) % nb);
        for (int i = 0; i < 4; i++) s[i] = (i >= o) && (i < o + nb);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] size, logic [31:0] wd);
        int nb;
        logic [31:0] w;
        nb = nbytes(size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_fmt(logic [31:0] raw, logic [1:0] size, logic sgn,
                                          logic [31:0] addr);
        int nb;
        int o;
        logic [31:0] v;
        logic [31:0] mask;
        nb   = nbytes(size);
        o    = int'(addr[1:0]) - (int'(addr[1:0]) % nb);
        v    = raw >> (8 * o);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = v & mask;
        if (sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Transaction flags: request accepted and awaiting response; response just arrived.
    bit          m_busy;
    bit          m_done;
    logic [31:0] m_cap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cap  <= 32'h0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (dbus_rvalid) begin
                m_cap  <= dbus_rdata;
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (mem_type != MEM_NOOP && !m_mis(mem_size, mem_addr) && dbus_ready) begin
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin : cmp
        bit legal;
        bit ereq;
        legal = (mem_type != MEM_NOOP) && !m_mis(mem_size, mem_addr);
        ereq  = !rst && !m_busy && !m_done && legal;
        chk("req", {31'b0, dbus_req}, {31'b0, ereq});
        chk("stall", {31'b0, mem_stall}, {31'b0, !rst && (m_busy || ereq)});
        chk("addr_error", {31'b0, addr_error},
            {31'b0, !rst && (mem_type != MEM_NOOP) && m_mis(mem_size, mem_addr)});
        if (ereq) begin
            chk("bus_addr", dbus_addr, {mem_addr[31:2], 2'b00});
            chk("wstrb", {28'b0, dbus_wstrb},
                {28'b0, (mem_type == MEM_STOR) ? m_strb(mem_size, mem_addr) : 4'b0000});
            if (mem_type == MEM_STOR) chk("wdata", dbus_wdata, m_wdata(mem_size, mem_wdata));
        end
        if (rst) chk("rdata_in_reset", mem_rdata, 32'h0);
        else if (m_done)
            chk("rdata_done", mem_rdata,
                (mem_type == MEM_STOR) ? 32'h0 : m_fmt(m_cap, mem_size, mem_signed, mem_addr));
    end

    always @(negedge clk) begin
        assert (mem_size != 2'b11) else $error("illegal mem_size presented");
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input logic [1:0] t, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        mem_type   = t;
        mem_size   = sz;
        mem_signed = sg;
        mem_addr   = a;
        mem_wdata  = wd;
    endtask

    // Runs one access from IDLE through DONE; called and returns at posedge+1.
    task automatic do_access(input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                             output logic [31:0] res, output int stalls, output int reqs,
                             output logic [31:0] f_addr, output logic [3:0] f_strb,
                             output logic [31:0] f_wdata);
        int  phase;
        int  wcyc;
        bit  fin;
        phase  = 0;
        wcyc   = 0;
        fin    = 1'b0;
        stalls = 0;
        reqs   = 0;
        res    = 32'h0;
        f_addr = 32'h0;
        f_strb = 4'h0;
        f_wdata = 32'h0;
        for (int n = 0; n < 64 && !fin; n++) begin
            dbus_ready  = (phase == 0) && (n >= rdy_dly);
            dbus_rvalid = (phase == 1) && (wcyc >= rv_dly);
            dbus_rdata  = rdata;
            @(negedge clk);
            if (mem_stall) stalls++;
            if (dbus_req) begin
                reqs++;
                if (reqs == 1) begin
                    f_addr  = dbus_addr;
                    f_strb  = dbus_wstrb;
                    f_wdata = dbus_wdata;
                end
            end
            if (phase == 0 && dbus_req && dbus_ready) phase = 1;
            else if (phase == 1) begin
                if (dbus_rvalid) fin = 1'b1;
                wcyc++;
            end
            @(posedge clk);
            #1;
        end
        dbus_ready  = 1'b0;
        dbus_rvalid = 1'b0;
        if (!fin) begin
            n_checks++;
            $display("FAIL access_timeout: got no completion, expected DONE within 64 cycles");
        end
        @(negedge clk);
        res = mem_rdata;
        if (mem_stall) stalls++;
        @(posedge clk);
        #1;
        mem_type = MEM_NOOP;
    endtask

    logic [31:0] res, fa, fw;
    logic [3:0]  fs;
    int          st, rq;

    initial begin
        rst         = 1'b1;
        dbus_ready  = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        set_op(MEM_LOAD, SZ_WORD, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("rst_req", {31'b0, dbus_req}, 32'h0);
        chk("rst_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_type = MEM_NOOP;
        @(posedge clk);
        #1;

        set_op(MEM_LOAD, SZ_WORD, 1'b0, 32'h100, 32'h0);
        do_access(0, 0, 32'hDEADBEEF, res, st, rq, fa, fs, fw);
        chk("lw_rdata", res, 32'hDEADBEEF);
        chk("lw_stalls", st, 2);
        chk("lw_addr", fa, 32'h100);
        chk("lw_wstrb", {28'b0, fs}, 32'h0);

        set_op(MEM_LOAD, SZ_BYTE, 1'b1, 32'h103, 32'h0);
        do_access(0, 0, 32'h80112233, res, st, rq, fa, fs, fw);
        chk("lb_rdata", res, 32'hFFFFFF80);
        set_op(MEM_LOAD, SZ_BYTE, 1'b0, 32'h103, 32'h0);
        do_access(0, 0, 32'h80112233, res, st, rq, fa, fs, fw);
        chk("lbu_rdata", res, 32'h00000080);

        set_op(MEM_STOR, SZ_HALF, 1'b0, 32'h202, 32'h0000ABCD);
        do_access(0, 0, 32'h0, res, st, rq, fa, fs, fw);
        chk("sh_addr", fa, 32'h200);
        chk("sh_wstrb", {28'b0, fs}, 32'hC);
        chk("sh_wdata", fw, 32'hABCDABCD);
        chk("sh_rdata", res, 32'h0);

        set_op(MEM_LOAD, SZ_WORD, 1'b0, 32'h101, 32'h0);
        @(negedge clk);
        chk("mis_err", {31'b0, addr_error}, 32'h1);
        chk("mis_req", {31'b0, dbus_req}, 32'h0);
        chk("mis_stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk);
        #1;
        set_op(MEM_STOR, SZ_HALF, 1'b0, 32'h203, 32'h1);
        @(negedge clk);
        chk("mis_sh_err", {31'b0, addr_error}, 32'h1);
        @(posedge clk);
        #1;

        set_op(MEM_LOAD, SZ_WORD, 1'b0, 32'h600, 32'h0);
        do_access(5, 2, 32'hCAFEF00D, res, st, rq, fa, fs, fw);
        chk("slow_reqs", rq, 6);
        chk("slow_stalls", st, 9);
        chk("slow_rdata", res, 32'hCAFEF00D);

        set_op(MEM_LOAD, SZ_HALF, 1'b1, 32'h102, 32'h0);
        do_access(0, 1, 32'h80017FFF, res, st, rq, fa, fs, fw);
        chk("lh_rdata", res, 32'hFFFF8001);
        set_op(MEM_LOAD, SZ_HALF, 1'b0, 32'h100, 32'h0);
        do_access(1, 0, 32'h80017FFF, res, st, rq, fa, fs, fw);
        chk("lhu_rdata", res, 32'h00007FFF);

        set_op(MEM_STOR, SZ_BYTE, 1'b0, 32'h301, 32'h1234565A);
        do_access(0, 0, 32'h0, res, st, rq, fa, fs, fw);
        chk("sb_wstrb", {28'b0, fs}, 32'h2);
        chk("sb_wdata", fw, 32'h5A5A5A5A);
        set_op(MEM_STOR, SZ_WORD, 1'b0, 32'h400, 32'h01020304);
        do_access(0, 0, 32'h0, res, st, rq, fa, fs, fw);
        chk("sw_wstrb", {28'b0, fs}, 32'hF);
        chk("sw_wdata", fw, 32'h01020304);

        // Reset while waiting for the response; a later stray rvalid must be ignored.
        set_op(MEM_LOAD, SZ_WORD, 1'b0, 32'h500, 32'h0);
        dbus_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        dbus_ready = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'b0, mem_stall}, 32'h1);
        chk("wait_req", {31'b0, dbus_req}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_type = MEM_NOOP;
        @(posedge clk);
        #1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h12345678;
        @(posedge clk);
        #1;
        dbus_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_rvalid_rdata", mem_rdata, 32'h0);
        chk("stray_rvalid_stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage data-access engine of the 5-stage MIPS pipeline.
- Takes the load/store held in the EX/MEM register and drives the data bus request/response handshake.
- Aligns store data and byte strobes; formats load data (sign/zero extension).
- Produces mem_stall, which the hazard/enable control unit consumes. While mem_stall is high, every pipeline register enable is low, so all inputs here are held stable.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus and register data width. Fixed at 32; any other value is illegal.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- mem_type  in  2  MEM_NOOP / MEM_LOAD / MEM_STOR from EX/MEM
- mem_size  in  2  SZ_BYTE / SZ_HALF / SZ_WORD
- mem_signed  in  1  1 = sign-extend loads (lb/lh), 0 = zero-extend (lbu/lhu)
- mem_addr  in  32  effective address
- mem_wdata  in  32  store source register value (unaligned, in LSBs)
- dbus_req  out  1  request valid
- dbus_ready  in  1  slave accepts request this cycle
- dbus_addr  out  32  word-aligned address ({mem_addr[31:2],2'b00})
- dbus_wstrb  out  4  byte write strobes; 0 for loads
- dbus_wdata  out  32  lane-aligned store data
- dbus_rvalid  in  1  response valid (read data or write ack)
- dbus_rdata  in  32  raw read word
- mem_rdata  out  32  formatted load result to MEM/WB
- addr_error  out  1  misaligned access (AdEL/AdES) to the exception logic
- mem_stall  out  1  stall request to the control unit

Behaviour:
- FSM states: IDLE, WAIT, DONE. Reset puts the FSM in IDLE and clears the raw-data register to 0.
- Outputs in reset: dbus_req=0, mem_stall=0, addr_error=0, mem_rdata=0.
- op_valid = (mem_type != MEM_NOOP).
- misaligned = (half && addr[0]) || (word && addr[1:0] != 0).
- addr_error = op_valid && misaligned, combinational. A misaligned op issues no bus request and raises no stall.
- IDLE:
  - dbus_req = op_valid && !misaligned.
  - mem_stall = dbus_req.
  - dbus_req && dbus_ready -> WAIT. Otherwise stay in IDLE with dbus_req held (no retraction until accepted).
- WAIT:
  - dbus_req=0, mem_stall=1.
  - dbus_rvalid -> capture dbus_rdata, go to DONE.
  - No timeout.
- DONE:
  - mem_stall=0 and mem_rdata is valid. The pipeline advances at this edge, because mem_wb_en=1 whenever mem_stall=0.
  - Unconditional transition to IDLE.
  - A new op presented in the next cycle starts in IDLE.
- Latency with ready and rvalid each asserted at the first opportunity: 3 cycles, with stall high for 2 of them.
- dbus_rvalid in IDLE or DONE is ignored: no capture, no state change.
- dbus_ready in WAIT or DONE is ignored (dbus_req is 0 there).
- Store alignment (little-endian):
  - byte: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'b1111; wdata passed through.
- Loads: wstrb = 0.
- Load format:
  - Select the lane of the captured word by the live (stable) mem_addr[1:0] and mem_size.
  - Extend according to mem_signed.
  - Stores return mem_rdata = 0.
- mem_rdata is driven every cycle from the captured register. It is meaningful only in DONE.
- Reset mid-operation (WAIT or DONE): FSM returns to IDLE immediately. Any stale response is the bus fabric's responsibility; the fabric is reset by the same rst.
- mem_size encoding 2'b11 is illegal: treated as word, and the bench asserts it never occurs.

Decomposition:
- Shared package / common.vh:
  - MEM_NOOP/MEM_LOAD/MEM_STOR encodings, alongside the existing MEM_LOAD.
  - SZ_BYTE/SZ_HALF/SZ_WORD encodings.
  - dmem_state_t enum (IDLE, WAIT, DONE).
- One combinational sub-module: dmem_lane_align. It holds both store strobe/data alignment and load extraction/extension, and is unit-testable on its own. The FSM and handshake stay in the top module.

Test Plan:
- lw at 0x100, ready=1 at once, rvalid next cycle with rdata=0xDEADBEEF -> stall high 2 cycles, DONE mem_rdata=0xDEADBEEF, dbus_addr=0x100, wstrb=0.
- lb signed at 0x103, rdata=0x80112233 -> mem_rdata=0xFFFFFF80. Same access as lbu -> mem_rdata=0x00000080.
- sh at 0x202, wdata=0x0000ABCD -> dbus_addr=0x200, wstrb=4'b1100, dbus_wdata=0xABCDABCD.
- lw at 0x101 -> addr_error=1, dbus_req=0, mem_stall=0 in the same cycle.
- ready held low for 5 cycles then high, rvalid 3 cycles later -> dbus_req stable with constant addr for all 6 cycles, stall high throughout, then one DONE cycle.
- Assert rst in WAIT -> FSM in IDLE, mem_stall=0, and a later rvalid pulse is ignored (no DONE).
